// File: rtl/perf_counter_bank_pkg.sv
// Shared register map, CFG field positions and helpers for the performance counter bank.
package perf_counter_bank_pkg;

  localparam logic [7:0] OffCtrl      = 8'h00;
  localparam logic [7:0] OffStatus    = 8'h04;
  localparam logic [7:0] OffId        = 8'h08;
  localparam logic [7:0] OffCntBase   = 8'h20;
  localparam logic [7:0] OffCntStride = 8'h10;

  // Register offsets inside one counter window
  localparam logic [3:0] OffCfg = 4'h0;
  localparam logic [3:0] OffLo  = 4'h4;
  localparam logic [3:0] OffHi  = 4'h8;

  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlFreezeBit = 1;

  localparam int unsigned CfgEnBit   = 0;
  localparam int unsigned CfgModeBit = 1;
  localparam int unsigned CfgSelLsb  = 4;
  localparam int unsigned CfgSelMsb  = 7;
  localparam int unsigned CfgIrqBit  = 8;

  localparam logic [7:0] IdVersion = 8'h01;

  typedef struct packed {
    logic       irq_en;
    logic [3:0] sel;
    logic       mode;
    logic       en;
  } cnt_cfg_t;

  // Address bits [7:4] that select counter idx
  function automatic logic [3:0] cnt_slot(input int unsigned idx);
    return 4'(idx + 32'(OffCntBase >> 4));
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// MMIO bus and interrupt between the core's decode and the counter bank.
interface perf_counter_bank_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output wdata, output wen, output ren, input rdata, input irq);
  modport slave  (input addr, input wdata, input wen, input ren, output rdata, output irq);
endinterface

// File: rtl/perf_counter_bank_slice.sv
// One counter: CFG register, CNT_WIDTH-bit counter, HI read shadow and wrap detection.
module perf_counter_bank_slice
  import perf_counter_bank_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_en,
  input  logic [15:0] events,
  input  logic [15:0] events_prev,
  input  logic        cfg_we,
  input  logic        lo_we,
  input  logic        hi_we,
  input  logic        lo_re,
  input  logic [31:0] wdata,
  output logic [31:0] cfg_rd,
  output logic [31:0] lo_rd,
  output logic [31:0] hi_rd,
  output logic        irq_en,
  output logic        ovf
);

  cnt_cfg_t             cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          shadow_q;
  logic [63:0]          cnt_ext, cnt_wr;
  logic                 sel_event, inc;

  assign cnt_ext = 64'(cnt_q);

  // Events vectors are zero-padded to 16, so an out-of-range select never fires
  assign sel_event = cfg_q.mode ? (events[cfg_q.sel] & ~events_prev[cfg_q.sel])
                                : events[cfg_q.sel];
  assign inc = count_en & cfg_q.en & sel_event;

  always_comb begin
    cfg_d = cfg_q;
    if (cfg_we) begin
      cfg_d.en     = wdata[CfgEnBit];
      cfg_d.mode   = wdata[CfgModeBit];
      cfg_d.sel    = wdata[CfgSelMsb:CfgSelLsb];
      cfg_d.irq_en = wdata[CfgIrqBit];
    end
  end

  always_comb begin
    cnt_wr = cnt_ext;
    if (lo_we) cnt_wr[31:0]  = wdata;
    if (hi_we) cnt_wr[63:32] = wdata;
    cnt_d = cnt_q;
    ovf   = 1'b0;
    // A register write wins over an increment; the increment is dropped
    if (lo_we || hi_we) begin
      cnt_d = cnt_wr[CNT_WIDTH-1:0];
    end else if (inc) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      ovf   = &cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      if (lo_re) shadow_q <= cnt_ext[63:32];
    end
  end

  assign cfg_rd = {23'd0, cfg_q.irq_en, cfg_q.sel, 2'b00, cfg_q.mode, cfg_q.en};
  assign lo_rd  = cnt_ext[31:0];
  assign hi_rd  = shadow_q;
  assign irq_en = cfg_q.irq_en;

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of NUM_CNT event counters with sticky overflow status and an interrupt.
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned NUM_EVENTS = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  perf_counter_bank_if.slave    bus
);

  logic               hit;
  logic [7:0]         off;
  logic [3:0]         slot, sub;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [NUM_CNT-1:0] status_q, status_d, w1c, ovf, irq_en;
  logic [15:0]        ev_ext, ev_prev_q;
  logic [31:0]        rd_mux, rdata_q, id_word;
  logic               irq_q, count_en;
  logic [31:0]        cfg_rd [NUM_CNT];
  logic [31:0]        lo_rd  [NUM_CNT];
  logic [31:0]        hi_rd  [NUM_CNT];

  assign hit      = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign off      = bus.addr[7:0];
  assign slot     = off[7:4];
  assign sub      = off[3:0];
  assign ev_ext   = 16'(events);
  assign count_en = ctrl_q[CtrlEnBit] & ~ctrl_q[CtrlFreezeBit];
  assign id_word  = {8'(NUM_CNT), 8'(NUM_EVENTS), 8'(CNT_WIDTH), IdVersion};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    logic cnt_hit;
    assign cnt_hit = hit & (slot == cnt_slot(g));

    perf_counter_bank_slice #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_slice (
      .clk         (clk),
      .rst         (rst),
      .count_en    (count_en),
      .events      (ev_ext),
      .events_prev (ev_prev_q),
      .cfg_we      (bus.wen & cnt_hit & (sub == OffCfg)),
      .lo_we       (bus.wen & cnt_hit & (sub == OffLo)),
      .hi_we       (bus.wen & cnt_hit & (sub == OffHi)),
      .lo_re       (bus.ren & cnt_hit & (sub == OffLo)),
      .wdata       (bus.wdata),
      .cfg_rd      (cfg_rd[g]),
      .lo_rd       (lo_rd[g]),
      .hi_rd       (hi_rd[g]),
      .irq_en      (irq_en[g]),
      .ovf         (ovf[g])
    );
  end

  always_comb begin
    ctrl_d = ctrl_q;
    w1c    = '0;
    if (bus.wen && hit && off == OffCtrl)   ctrl_d = bus.wdata[1:0];
    if (bus.wen && hit && off == OffStatus) w1c    = bus.wdata[NUM_CNT-1:0];
    // A fresh overflow beats a coincident clear
    status_d = (status_q & ~w1c) | ovf;
  end

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      if (slot < 4'd2) begin
        case (off)
          OffCtrl:   rd_mux = 32'(ctrl_q);
          OffStatus: rd_mux = 32'(status_q);
          OffId:     rd_mux = id_word;
          default:   rd_mux = '0;
        endcase
      end else begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (slot == cnt_slot(i)) begin
            case (sub)
              OffCfg:  rd_mux = cfg_rd[i];
              OffLo:   rd_mux = lo_rd[i];
              OffHi:   rd_mux = hi_rd[i];
              default: rd_mux = '0;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      status_q  <= '0;
      ev_prev_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      ev_prev_q <= ev_ext;
      rdata_q   <= bus.ren ? rd_mux : '0;
      irq_q     <= |(status_q & irq_en);
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Two banks (64-bit and 8-bit counters) on one broadcast bus, checked every cycle against a model.
module tb_perf_counter_bank;

  localparam logic [31:0] BASE = 32'h8000_0100;
  localparam int NEV = 8;
  localparam int NC  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ev;
  logic [31:0] addr, wdata;
  logic        wen, ren;
  int          checks = 0;
  int          failures = 0;

  perf_counter_bank_if bus_a ();
  perf_counter_bank_if bus_b ();

  assign bus_a.addr = addr;
  assign bus_a.wdata = wdata;
  assign bus_a.wen = wen;
  assign bus_a.ren = ren;
  assign bus_b.addr = addr;
  assign bus_b.wdata = wdata;
  assign bus_b.wen = wen;
  assign bus_b.ren = ren;

  perf_counter_bank #(
    .NUM_CNT (NC), .CNT_WIDTH (64), .NUM_EVENTS (NEV), .BASE_ADDR (BASE)
  ) u_a (
    .clk (clk), .rst (rst), .events (ev), .bus (bus_a.slave)
  );

  perf_counter_bank #(
    .NUM_CNT (NC), .CNT_WIDTH (8), .NUM_EVENTS (NEV), .BASE_ADDR (BASE)
  ) u_b (
    .clk (clk), .rst (rst), .events (ev), .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 is the 64-bit bank, index 1 the 8-bit bank
  int               wid [2] = '{64, 8};
  longint unsigned  m_cnt [2][NC];
  logic [31:0]      m_shadow [2][NC];
  logic [NC-1:0]    m_status [2];
  logic             m_irq [2];
  logic [31:0]      m_rdata [2];
  logic [1:0]       m_ctrl;
  logic             m_en [NC];
  logic             m_mode [NC];
  logic             m_irqen [NC];
  logic [3:0]       m_sel [NC];
  logic [7:0]       m_prev;

  function automatic longint unsigned wmask(input int w);
    if (w >= 64) return 64'hFFFF_FFFF_FFFF_FFFF;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [7:0] coff(input int c, input int s);
    return 8'(32 + 16 * c + s);
  endfunction

  function automatic logic [31:0] read_reg(input int n, input logic [7:0] o);
    int c, s;
    if (o == 8'h00) return {30'd0, m_ctrl};
    if (o == 8'h04) return {28'd0, m_status[n]};
    if (o == 8'h08) return {8'd4, 8'd8, 8'(wid[n]), 8'd1};
    if (o < 8'h20) return 32'd0;
    c = (int'(o) - 32) / 16;
    s = int'(o) % 16;
    if (c >= NC) return 32'd0;
    case (s)
      0: return {23'd0, m_irqen[c], m_sel[c], 2'b00, m_mode[c], m_en[c]};
      4: return m_cnt[n][c][31:0];
      8: return m_shadow[n][c];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0;
    m_prev = '0;
    for (int k = 0; k < NC; k++) begin
      m_en[k] = 0; m_mode[k] = 0; m_irqen[k] = 0; m_sel[k] = '0;
    end
    for (int n = 0; n < 2; n++) begin
      m_status[n] = '0; m_irq[n] = 0; m_rdata[n] = '0;
      for (int k = 0; k < NC; k++) begin
        m_cnt[n][k] = 0; m_shadow[n][k] = '0;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    logic          hit;
    logic [7:0]    o;
    int            c, s;
    logic          fire [NC];
    logic [NC-1:0] w1c, ien;
    hit = (addr[31:8] == BASE[31:8]);
    o = addr[7:0];
    c = (o >= 8'h20) ? (int'(o) - 32) / 16 : -1;
    s = int'(o) % 16;
    for (int k = 0; k < NC; k++) begin
      int e;
      e = int'(m_sel[k]);
      if (e >= NEV) fire[k] = 0;
      else if (m_mode[k]) fire[k] = ev[e] && !m_prev[e];
      else fire[k] = ev[e];
      fire[k] = fire[k] && m_en[k] && m_ctrl[0] && !m_ctrl[1];
      ien[k] = m_irqen[k];
    end
    w1c = (wen && hit && o == 8'h04) ? wdata[NC-1:0] : '0;
    for (int n = 0; n < 2; n++) begin
      longint unsigned mk;
      logic [NC-1:0]   ovf;
      mk = wmask(wid[n]);
      ovf = '0;
      m_irq[n] = |(m_status[n] & ien);
      m_rdata[n] = (ren && hit) ? read_reg(n, o) : 32'd0;
      if (ren && hit && c >= 0 && c < NC && s == 4)
        m_shadow[n][c] = 32'(m_cnt[n][c] >> 32);
      for (int k = 0; k < NC; k++) begin
        if (wen && hit && c == k && s == 4)
          m_cnt[n][k] = ((m_cnt[n][k] & 64'hFFFF_FFFF_0000_0000) | {32'd0, wdata}) & mk;
        else if (wen && hit && c == k && s == 8)
          m_cnt[n][k] = ((m_cnt[n][k] & 64'h0000_0000_FFFF_FFFF) | {wdata, 32'd0}) & mk;
        else if (fire[k]) begin
          if (m_cnt[n][k] == mk) begin
            m_cnt[n][k] = 0;
            ovf[k] = 1'b1;
          end else m_cnt[n][k] = m_cnt[n][k] + 1;
        end
      end
      m_status[n] = (m_status[n] & ~w1c) | ovf;
    end
    if (wen && hit && o == 8'h00) m_ctrl = wdata[1:0];
    if (wen && hit && c >= 0 && c < NC && s == 0) begin
      m_en[c] = wdata[0]; m_mode[c] = wdata[1]; m_sel[c] = wdata[7:4]; m_irqen[c] = wdata[8];
    end
    m_prev = ev;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("rdata_a", bus_a.rdata, m_rdata[0]);
    chk("irq_a", {31'd0, bus_a.irq}, {31'd0, m_irq[0]});
    chk("rdata_b", bus_b.rdata, m_rdata[1]);
    chk("irq_b", {31'd0, bus_b.irq}, {31'd0, m_irq[1]});
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re);
    addr = a; wdata = d; wen = we; ren = re;
    step();
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d);
    op(BASE + 32'(o), d, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [7:0] o);
    op(BASE + 32'(o), 32'd0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] ra, rd_data;
    addr = BASE; wdata = '0; wen = 1'b0; ren = 1'b0; ev = 8'h01;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata_a", bus_a.rdata, 32'd0);
    chk("reset_irq_a", {31'd0, bus_a.irq}, 32'd0);
    chk("reset_rdata_b", bus_b.rdata, 32'd0);
    chk("reset_irq_b", {31'd0, bus_b.irq}, 32'd0);
    rst = 1'b1;

    // Cycle count in level mode, then freeze
    wr(8'h00, 32'd1);
    wr(coff(0, 0), 32'h001);
    idle(100);
    rd(coff(0, 4));
    chk("cycles_a", bus_a.rdata, 32'd100);
    chk("cycles_b", bus_b.rdata, 32'd100);
    wr(8'h00, 32'd3);
    idle(50);
    rd(coff(0, 4));
    chk("frozen_a", bus_a.rdata, 32'd102);
    wr(coff(0, 0), 32'h000);

    // Level vs edge on event 3
    wr(coff(1, 0), 32'h031);
    wr(coff(2, 0), 32'h033);
    wr(8'h00, 32'd1);
    for (int b = 0; b < 4; b++) begin
      ev[3] = 1'b1; idle(10);
      ev[3] = 1'b0; idle(5);
    end
    rd(coff(1, 4));
    chk("level_a", bus_a.rdata, 32'd40);
    rd(coff(2, 4));
    chk("edge_a", bus_a.rdata, 32'd4);
    wr(coff(1, 0), 32'h0);
    wr(coff(2, 0), 32'h0);

    // Wrap, irq and W1C on the 8-bit bank
    wr(coff(3, 4), 32'hFE);
    wr(coff(3, 0), 32'h101);
    idle(2);
    chk("wrap_cnt_status_b", {31'd0, bus_b.irq}, 32'd0);
    idle(1);
    chk("irq_set_b", {31'd0, bus_b.irq}, 32'd1);
    wr(8'h04, 32'h8);
    idle(1);
    chk("irq_clear_b", {31'd0, bus_b.irq}, 32'd0);
    wr(coff(3, 4), 32'hFE);
    idle(1);
    wr(8'h04, 32'h8);
    rd(8'h04);
    chk("w1c_vs_set_b", bus_b.rdata, 32'h8);
    wr(coff(3, 0), 32'h0);
    wr(8'h04, 32'hF);

    // Atomic 64-bit read
    wr(coff(3, 8), 32'h0);
    wr(coff(3, 4), 32'hFFFF_FFFF);
    wr(coff(3, 0), 32'h001);
    rd(coff(3, 4));
    chk("atomic_lo_a", bus_a.rdata, 32'hFFFF_FFFF);
    chk("atomic_lo_b", bus_b.rdata, 32'hFF);
    rd(coff(3, 8));
    chk("atomic_hi_a", bus_a.rdata, 32'h0);
    chk("hi_narrow_b", bus_b.rdata, 32'h0);
    rd(coff(3, 4));
    rd(coff(3, 8));
    chk("atomic_hi2_a", bus_a.rdata, 32'h1);
    wr(coff(3, 0), 32'h0);
    wr(8'h04, 32'hF);

    // Write/increment collision and limits
    wr(coff(0, 0), 32'h001);
    wr(coff(0, 4), 32'd5);
    rd(coff(0, 4));
    chk("collision_a", bus_a.rdata, 32'd5);
    wr(coff(0, 0), 32'h0);
    wr(coff(1, 4), 32'd0);
    wr(coff(1, 0), 32'h0F1);
    idle(5);
    rd(coff(1, 4));
    chk("sel15_a", bus_a.rdata, 32'd0);
    op(BASE + 32'(coff(1, 4)), 32'd7, 1'b1, 1'b1);
    chk("rw_same_old_a", bus_a.rdata, 32'd0);
    rd(coff(1, 4));
    chk("rw_same_new_a", bus_a.rdata, 32'd7);
    wr(8'h04, 32'hF);
    rd(coff(NC, 4));
    chk("cnt_beyond_a", bus_a.rdata, 32'd0);
    rd(8'h08);
    chk("id_a", bus_a.rdata, 32'h0408_4001);
    chk("id_b", bus_b.rdata, 32'h0408_0801);
    op(32'h8000_0204, 32'd0, 1'b0, 1'b1);
    chk("miss_a", bus_a.rdata, 32'd0);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      int kind;
      ev = 8'($urandom) | 8'h01;
      kind = $urandom_range(0, 9);
      if (kind == 0) ra = BASE;
      else if (kind == 1) ra = BASE + 32'h04;
      else if (kind == 2) ra = BASE + 32'h08;
      else if (kind == 3) ra = BASE + 32'h0C;
      else if (kind == 9) ra = 32'h8000_0000 | 32'($urandom_range(0, 255) & 8'hFC);
      else ra = BASE + 32'(coff($urandom_range(0, NC), 4 * $urandom_range(0, 3)));
      case ($urandom_range(0, 3))
        0: rd_data = $urandom;
        1: rd_data = 32'hFFFF_FFFF;
        2: rd_data = 32'hFFFF_FFF8;
        default: rd_data = 32'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0: op(ra, rd_data, 1'b0, 1'b0);
        1: op(ra, rd_data, 1'b0, 1'b1);
        2: op(ra, rd_data, 1'b1, 1'b0);
        default: op(ra, rd_data, 1'b1, 1'b1);
      endcase
    end

    // Async reset mid-count with irq high and rdata non-zero
    ev = 8'h01;
    wr(8'h00, 32'd1);
    wr(coff(0, 0), 32'h0);
    wr(coff(0, 8), 32'hFFFF_FFFF);
    wr(coff(0, 4), 32'hFFFF_FFFF);
    wr(coff(0, 0), 32'h101);
    idle(2);
    rd(8'h00);
    chk("pre_reset_irq_a", {31'd0, bus_a.irq}, 32'd1);
    chk("pre_reset_rdata_a", bus_a.rdata, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rdata_a", bus_a.rdata, 32'd0);
    chk("async_irq_a", {31'd0, bus_a.irq}, 32'd0);
    chk("async_rdata_b", bus_b.rdata, 32'd0);
    chk("async_irq_b", {31'd0, bus_b.irq}, 32'd0);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    rd(8'h04);
    chk("post_reset_status_a", bus_a.rdata, 32'd0);
    chk("post_reset_status_b", bus_b.rdata, 32'd0);
    rd(coff(0, 4));
    chk("post_reset_cnt_a", bus_a.rdata, 32'd0);
    rd(coff(0, 0));
    chk("post_reset_cfg_a", bus_a.rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
